inst_fetch: RTL
===============

# inst_fetch

Instruction fetch stage of the single-issue CPU. It owns the program counter, drives the word address of the combinational instruction ROM, and captures the returned instruction into the IF/ID pipeline register. It also splits the instruction into registered decode fields for the decode stage and honours stall and branch-redirect requests from downstream.

## Interface
Parameters:
- `ADDR_W`, 6: PC / ROM word-address width (64-word ROM).
- `RESET_PC`, 0: PC value loaded on reset.
- `HALT_ON_WRAP`, 1: 1 = stop fetching after address 2^ADDR_W−1; 0 = wrap to 0 and continue.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  leave IDLE and begin fetching.
- `stall`  in  1  hold PC and IF/ID register.
- `redirect_valid`  in  1  branch/jump taken; flush and reload PC.
- `redirect_pc`  in  ADDR_W  target word address.
- `rom_addr`  out  ADDR_W  combinational, always equals `pc`.
- `rom_inst`  in  32  ROM data for `rom_addr` (same cycle).
- `id_valid`  out  1  IF/ID register holds a real instruction.
- `id_pc`  out  ADDR_W  address of `id_inst`.
- `id_inst`  out  32  raw instruction.
- `id_op` [31:26], `id_func` [25:20], `id_shamt` [19:15], `id_rd` [14:10], `id_rs` [9:5], `id_rt` [4:0]  out  6/6/5/5/5/5  registered fields of `id_inst`.
- `id_imm`  out  32  sign-extended `inst[25:10]`.
- `halted`  out  1  FSM in HALT.

## Operation
- FSM states: IDLE, RUN, HALT.
  - IDLE: PC is held; `id_valid` is 0. `start` moves the FSM to RUN with the PC unchanged.
  - RUN: on every edge without `stall`:
    - IF/ID loads `rom_inst`, `pc` and the decoded fields.
    - `id_valid` goes to 1.
    - `pc` increments by 1, modulo 2^ADDR_W.
    - If `pc` was all-ones and HALT_ON_WRAP = 1, the FSM goes to HALT and `pc` stays at all-ones.
  - HALT: the first edge without `stall` clears `id_valid`. After that, outputs are static.
- Per-edge priority: reset > `redirect_valid` > `stall` > advance.
- Redirect, in any state:
  - `pc` is loaded with `redirect_pc`.
  - `id_valid` is cleared (bubble); the `id_*` data fields hold.
  - From HALT the FSM returns to RUN; from IDLE it stays in IDLE.
  - `redirect_valid` together with `stall`: the redirect wins.
- Stall: `pc`, state and all `id_*` outputs hold their values exactly.
- `start` is ignored outside IDLE.
- Reset values: `pc` = RESET_PC, state = IDLE, `id_valid` = 0, `id_pc` = 0, `id_inst` and all fields = 0, `id_imm` = 0, `halted` = 0.

## Timing
- Fetch latency is 1 cycle. `rom_addr` = `pc` is combinational, and the instruction appears on `id_*` after the next edge.
- `start` sampled at edge k puts the FSM in RUN. At edge k+1, `id_valid` = 1 and `id_pc` = RESET_PC.
- Redirect sampled at edge k: `id_valid` = 0 after k. The target instruction is valid after edge k+1 (one-bubble penalty).
- `stall` acts in the same cycle: a stall high before edge k means nothing changes at edge k.
- Reset mid-operation: all registers go to their reset values immediately, asynchronously. Deassertion takes effect at the first following edge.
- Throughput is 1 instruction per cycle with no stalls.

## Structure
- Shared package `cpu_pkg`:
  - `ADDR_W` default.
  - Field bit-position constants: `OP_HI`/`OP_LO`, `FUNC_*`, `SHAMT_*`, `RD_*`, `RS_*`, `RT_*`, `IMM_*`.
  - Fetch-state enum `fetch_state_t`.
  - `NOP` = 32'h0.
- Sub-module `inst_fields`: combinational slicing and sign-extension of a 32-bit word into op/func/shamt/rd/rs/rt/imm. It is instantiated on the `rom_inst` path before the IF/ID register, and the decode stage reuses it.

## Test plan
- Reset, then `start` at edge 0 with the current program image:
  - Edge 1: `id_pc` = 0, `id_inst` = 0x00000000, `id_valid` = 1.
  - Edge 2: `id_pc` = 1, `id_inst` = 0x00100443, op = 0, func = 1, rd = 1, rs = 2, rt = 3.
- Fetch of address 4:
  - `id_inst` = 0x14002828, `id_op` = 5, `id_imm` = 0x0000000A, rs = 1, rt = 8.
  - Next cycle, address 5: `id_inst` = 0x37FFD501, `id_imm` = 0xFFFFFFF5.
- `stall` high for 3 cycles while `id_pc` = 2 → `id_*`, `rom_addr` = 3 and the state are unchanged for 3 edges; fetch then resumes with `id_pc` = 3.
- `redirect_valid` = 1, `redirect_pc` = 0x04, with `stall` also high, while `pc` = 6 → next edge: `id_valid` = 0, `pc` = 4; the edge after: `id_pc` = 4, `id_valid` = 1.
- Redirect to 0x3E with HALT_ON_WRAP = 1:
  - `id_pc` reaches 0x3F, then `halted` = 1 and `id_valid` = 0 one edge later.
  - A redirect to 0x01 restarts in RUN.
  - With HALT_ON_WRAP = 0, `id_pc` goes 0x3F → 0x00 with no gap.
- `rst_n` pulsed low mid-cycle while in RUN with `pc` = 0x10 → outputs immediately go to their reset values (`id_valid` = 0, `rom_addr` = 0), state = IDLE; fetching resumes only after `start`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout,
// fetch-state encoding and common constants.
package cpu_pkg;

   localparam int ADDR_W_DEFAULT = 6;

   localparam int OP_HI    = 31;
   localparam int OP_LO    = 26;
   localparam int FUNC_HI  = 25;
   localparam int FUNC_LO  = 20;
   localparam int SHAMT_HI = 19;
   localparam int SHAMT_LO = 15;
   localparam int RD_HI    = 14;
   localparam int RD_LO    = 10;
   localparam int RS_HI    = 9;
   localparam int RS_LO    = 5;
   localparam int RT_HI    = 4;
   localparam int RT_LO    = 0;
   localparam int IMM_HI   = 25;
   localparam int IMM_LO   = 10;

   localparam logic [31:0] NOP = 32'h0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/inst_fields.sv
// Splits a 32-bit instruction word into its fields;
// shared by fetch and decode.
module inst_fields
   import cpu_pkg::*;
(
   input  logic [31:0] inst,
   output logic [5:0]  op,
   output logic [5:0]  func,
   output logic [4:0]  shamt,
   output logic [4:0]  rd,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [31:0] imm
);

   assign op    = inst[OP_HI:OP_LO];
   assign func  = inst[FUNC_HI:FUNC_LO];
   assign shamt = inst[SHAMT_HI:SHAMT_LO];
   assign rd    = inst[RD_HI:RD_LO];
   assign rs    = inst[RS_HI:RS_LO];
   assign rt    = inst[RT_HI:RT_LO];
   assign imm   = {{16{inst[IMM_HI]}}, inst[IMM_HI:IMM_LO]};

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, reads the
// instruction ROM and fills the IF/ID register.
module inst_fetch
   import cpu_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEFAULT,
   parameter int RESET_PC     = 0,
   parameter bit HALT_ON_WRAP = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_inst,
   output logic              id_valid,
   output logic [ADDR_W-1:0] id_pc,
   output logic [31:0]       id_inst,
   output logic [5:0]        id_op,
   output logic [5:0]        id_func,
   output logic [4:0]        id_shamt,
   output logic [4:0]        id_rd,
   output logic [4:0]        id_rs,
   output logic [4:0]        id_rt,
   output logic [31:0]       id_imm,
   output logic              halted
);

   localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

   fetch_state_t      state;
   fetch_state_t      state_nxt;
   logic [ADDR_W-1:0] pc;
   logic              advance;
   logic              at_end;

   logic [5:0]  f_op;
   logic [5:0]  f_func;
   logic [4:0]  f_shamt;
   logic [4:0]  f_rd;
   logic [4:0]  f_rs;
   logic [4:0]  f_rt;
   logic [31:0] f_imm;

   inst_fields u_fields (
      .inst  (rom_inst),
      .op    (f_op),
      .func  (f_func),
      .shamt (f_shamt),
      .rd    (f_rd),
      .rs    (f_rs),
      .rt    (f_rt),
      .imm   (f_imm)
   );

   assign rom_addr = pc;
   assign advance  = (state == RUN) && !stall && !redirect_valid;
   assign at_end   = HALT_ON_WRAP && (pc == '1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (redirect_valid) begin
         if (state == HALT) state_nxt = RUN;
      end else if (!stall) begin
         unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (at_end) state_nxt = HALT;
            default: state_nxt = state;
         endcase
      end
   end

   always_comb begin
      halted = (state == HALT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= PC_RST;
      end else if (redirect_valid) begin
         pc <= redirect_pc;
      end else if (advance && !at_end) begin
         pc <= pc + 1'b1;
      end
   end

   // Only the valid bit reacts to a redirect; data holds as a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_valid <= 1'b0;
      end else if (redirect_valid) begin
         id_valid <= 1'b0;
      end else if (!stall) begin
         id_valid <= (state == RUN);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_pc    <= '0;
         id_inst  <= NOP;
         id_op    <= '0;
         id_func  <= '0;
         id_shamt <= '0;
         id_rd    <= '0;
         id_rs    <= '0;
         id_rt    <= '0;
         id_imm   <= '0;
      end else if (advance) begin
         id_pc    <= pc;
         id_inst  <= rom_inst;
         id_op    <= f_op;
         id_func  <= f_func;
         id_shamt <= f_shamt;
         id_rd    <= f_rd;
         id_rs    <= f_rs;
         id_rt    <= f_rt;
         id_imm   <= f_imm;
      end
   end

endmodule
